bist_sequencer: RTL and testbench

//   On-chip BIST controller for the core logic block, running in the clk domain.
//   - Generates DEPTH pseudo-random patterns with a 5-bit LFSR and drives them into the core logic.
//   - Compacts the core responses into a 16-bit MISR signature and compares it with GOLDEN_SIG.
//   - Reports busy/done/pass/abort plus a pattern count for the JTAG status register and the LEDs.

---
 rtl/bist_sequencer.sv | 142 ++++++++++++++
 tb/tb_bist_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
`default_nettype none
// bist_sequencer: LFSR pattern generator + 16-bit MISR compactor for core-logic BIST.
// Rev 1.0
module bist_sequencer #(
  parameter int          DEPTH      = 256,
  parameter int          LATENCY    = 1,
  parameter logic [4:0]  LFSR_SEED  = 5'h01,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  core_x,
  output logic        core_en,
  input  logic [3:0]  core_y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] status
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int DW = (LATENCY < 2) ? 1 : $clog2(LATENCY);
  localparam logic [PW-1:0] PAT_LAST   = PW'(DEPTH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((LATENCY == 0) ? 0 : LATENCY - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CMP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [4:0]    lfsr;
  logic [15:0]   misr;
  logic [PW-1:0] pat_cnt;
  logic [DW-1:0] drain_cnt;
  logic          aborted;
  logic          active, go, issue, cap_slot, capture;
  logic [31:0]   pat_ext;
  logic [11:0]   pat_sat;

  assign active  = (state == S_INIT) || (state == S_RUN) || (state == S_DRAIN) || (state == S_CMP);
  assign go      = start && !abort && ((state == S_IDLE) || (state == S_DONE));
  assign issue   = (state == S_RUN) && !abort;
  assign capture = cap_slot && !abort && ((state == S_RUN) || (state == S_DRAIN));

  // One valid bit per in-flight pattern marks the cycle its response reaches core_y.
  generate
    if (LATENCY == 0) begin : g_lat_zero
      assign cap_slot = issue;
    end else begin : g_lat_pipe
      logic [LATENCY-1:0] vpipe;
      always_ff @(posedge clk) begin
        if (rst || state == S_INIT) vpipe <= '0;
        else                        vpipe <= LATENCY'({vpipe, issue});
      end
      assign cap_slot = vpipe[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (go)                 state_nxt = S_INIT;
        else if (start && abort) state_nxt = S_IDLE;
      end
      S_INIT:  state_nxt = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                  state_nxt = S_IDLE;
        else if (pat_cnt == PAT_LAST) state_nxt = (LATENCY == 0) ? S_CMP : S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                       state_nxt = S_IDLE;
        else if (drain_cnt == DRAIN_LAST) state_nxt = S_CMP;
      end
      S_CMP:   state_nxt = abort ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_en = (state == S_RUN);
    core_x  = core_en ? lfsr : 5'h00;
    busy    = (state == S_INIT) || (state == S_RUN) || (state == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= LFSR_SEED;
      misr      <= '0;
      pat_cnt   <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      if (go) begin
        done    <= 1'b0;
        pass    <= 1'b0;
        aborted <= 1'b0;
      end
      if (state == S_INIT) begin
        lfsr    <= LFSR_SEED;
        misr    <= '0;
        pat_cnt <= '0;
      end
      if (issue) begin
        lfsr    <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        pat_cnt <= pat_cnt + 1'b1;
      end
      if (capture)
        misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {12'h000, core_y};
      if (state == S_CMP && !abort) begin
        pass <= (misr == GOLDEN_SIG);
        done <= 1'b1;
      end
      // Abort leaves misr/pat_cnt untouched so the partial run can be inspected.
      if (abort && active) begin
        aborted <= 1'b1;
        done    <= 1'b0;
        pass    <= 1'b0;
      end
    end
  end

  assign pat_ext   = 32'(pat_cnt);
  assign pat_sat   = (pat_ext > 32'h0000_0FFF) ? 12'hFFF : pat_ext[11:0];
  assign signature = misr;
  assign status    = {done, pass, busy, aborted, pat_sat};

endmodule
`default_nettype wire

// File: tb/tb_bist_sequencer.sv
`default_nettype none
// tb_bist_sequencer: randomized self-checking bench with a behavioural LFSR/MISR reference model.
module tb_bist_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0][4:0]  x;
  logic [3:0][15:0] sg, st;
  logic [3:0]       en, bsy, dn, ps;
  logic [3:0]       ya, yb, yc, yd, d1, d2;
  logic [3:0]       tbl [32];
  logic [4:0]       xs [$];
  int n_vec = 0, n_err = 0, sel = 0, xz_bad = 0;

  always #5 clk = ~clk;

  bist_sequencer #(.DEPTH(4), .LATENCY(1), .LFSR_SEED(5'h01), .GOLDEN_SIG(16'h0001)) u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .core_x(x[0]), .core_en(en[0]),
    .core_y(ya), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .signature(sg[0]), .status(st[0]));
  bist_sequencer #(.DEPTH(4), .LATENCY(1), .LFSR_SEED(5'h01), .GOLDEN_SIG(16'h0002)) u_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .core_x(x[1]), .core_en(en[1]),
    .core_y(yb), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .signature(sg[1]), .status(st[1]));
  bist_sequencer #(.DEPTH(1), .LATENCY(0), .LFSR_SEED(5'h01), .GOLDEN_SIG(16'h0001)) u_c (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .core_x(x[2]), .core_en(en[2]),
    .core_y(yc), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .signature(sg[2]), .status(st[2]));
  bist_sequencer #(.DEPTH(20), .LATENCY(3), .LFSR_SEED(5'h13), .GOLDEN_SIG(16'h1234)) u_d (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .core_x(x[3]), .core_en(en[3]),
    .core_y(yd), .busy(bsy[3]), .done(dn[3]), .pass(ps[3]), .signature(sg[3]), .status(st[3]));

  // Core stubs: identity with 1-cycle delay, identity combinational, random table with 3-cycle delay.
  always @(posedge clk) begin
    ya <= x[0][3:0];
    yb <= x[1][3:0];
    d1 <= tbl[x[3]];
    d2 <= d1;
    yd <= d2;
  end
  assign yc = x[2][3:0];

  function automatic logic [4:0] lfsr_at(input logic [4:0] seed, input int k);
    logic [4:0] v;
    v = seed;
    repeat (k) v = {v[3:0], v[4] ^ v[2]};
    return v;
  endfunction

  // Reference signature: fold the first n core responses into a CRC-style 16-bit register.
  function automatic logic [15:0] fold(input logic [4:0] seed, input int n, input bit use_tbl);
    logic [15:0] m;
    logic [4:0]  p;
    logic [3:0]  y;
    m = 16'h0000;
    for (int k = 0; k < n; k++) begin
      p = lfsr_at(seed, k);
      y = use_tbl ? tbl[p] : p[3:0];
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {12'h000, y};
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_run(input int bound, input int inject, output int edges);
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    xs.delete();
    xz_bad = 0;
    while (dn[sel] !== 1'b1 && edges < bound) begin
      if (en[sel]) xs.push_back(x[sel]);
      else if (x[sel] !== 5'h00) xz_bad++;
      start = (edges == inject);
      tick();
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({x[i], en[i], bsy[i], dn[i], ps[i], sg[i], st[i]} !== '0) begin
        n_err++; $display("FAIL por_outputs[%0d]: got sig=%h st=%h en=%b busy=%b want all 0", i, sg[i], st[i], en[i], bsy[i]);
      end
    end
    rst = 1'b0; sel = 0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (en[0] !== 1'b1) begin n_err++; $display("FAIL reset_prerun_en: got %b want 1", en[0]); end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({x[i], en[i], bsy[i], dn[i], ps[i], sg[i], st[i]} !== '0) begin
        n_err++; $display("FAIL midrun_reset[%0d]: got sig=%h st=%h en=%b busy=%b want all 0", i, sg[i], st[i], en[i], bsy[i]);
      end
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (bsy[0] !== 1'b0 || st[0] !== 16'h0000) begin
      n_err++; $display("FAIL reset_stays_idle: got busy=%b st=%h want 0/0000", bsy[0], st[0]);
    end
  endtask

  task automatic test_nominal();
    logic [4:0] exp_x [4];
    int e;
    bit ok;
    exp_x = '{5'h01, 5'h02, 5'h04, 5'h09};
    do_reset();
    sel = 0;
    do_run(40, -1, e);
    n_vec++;
    if (e != 8) begin n_err++; $display("FAIL nominal_done_latency: got %0d edges want 8", e); end
    ok = (xs.size() == 4);
    for (int k = 0; k < 4 && ok; k++) if (xs[k] !== exp_x[k]) ok = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL nominal_core_x_seq: got %0d patterns %p want 01,02,04,09", xs.size(), xs); end
    n_vec++;
    if (xz_bad != 0) begin n_err++; $display("FAIL core_x_idle_zero: got %0d nonzero want 0", xz_bad); end
    n_vec++;
    if (sg[0] !== fold(5'h01, 4, 0)) begin n_err++; $display("FAIL nominal_sig: got %h want %h", sg[0], fold(5'h01, 4, 0)); end
    n_vec++;
    if ({dn[0], ps[0], st[0]} !== {2'b11, 16'hC004}) begin
      n_err++; $display("FAIL nominal_status: got done=%b pass=%b st=%h want 1/1/C004", dn[0], ps[0], st[0]);
    end
    n_vec++;
    if ({dn[1], ps[1], st[1], sg[1]} !== {2'b10, 16'h8004, 16'h0001}) begin
      n_err++; $display("FAIL mismatch_status: got done=%b pass=%b st=%h sig=%h want 1/0/8004/0001", dn[1], ps[1], st[1], sg[1]);
    end
  endtask

  task automatic test_start_in_done();
    int e;
    sel = 0;
    do_run(40, -1, e);
    n_vec++;
    if (e != 8) begin n_err++; $display("FAIL rerun_latency: got %0d edges want 8", e); end
    n_vec++;
    if ({sg[0], st[0]} !== {16'h0001, 16'hC004}) begin
      n_err++; $display("FAIL rerun_result: got sig=%h st=%h want 0001/C004", sg[0], st[0]);
    end
  endtask

  task automatic test_start_during_run();
    int e;
    do_reset();
    sel = 0;
    do_run(40, 3, e);
    n_vec++;
    if (e != 8 || xs.size() != 4) begin
      n_err++; $display("FAIL start_in_run_timing: got %0d edges %0d patterns want 8/4", e, xs.size());
    end
    n_vec++;
    if ({sg[0], st[0]} !== {16'h0001, 16'hC004}) begin
      n_err++; $display("FAIL start_in_run_result: got sig=%h st=%h want 0001/C004", sg[0], st[0]);
    end
  endtask

  task automatic test_start_abort_idle();
    do_reset();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    n_vec++;
    if ({bsy[0], st[0]} !== 17'h0) begin n_err++; $display("FAIL start_abort_idle: got busy=%b st=%h want 0/0000", bsy[0], st[0]); end
    tick();
    n_vec++;
    if ({bsy[0], en[0]} !== 2'b00) begin n_err++; $display("FAIL start_abort_idle_hold: got busy=%b en=%b want 0/0", bsy[0], en[0]); end
  endtask

  task automatic test_abort();
    logic [15:0] sig_before;
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({en[0], bsy[0], dn[0], st[0]} !== {3'b000, 16'h1002}) begin
      n_err++; $display("FAIL abort_status: got en=%b busy=%b done=%b st=%h want 0/0/0/1002", en[0], bsy[0], dn[0], st[0]);
    end
    n_vec++;
    if (sg[0] !== fold(5'h01, 1, 0)) begin n_err++; $display("FAIL abort_sig_frozen: got %h want %h", sg[0], fold(5'h01, 1, 0)); end
    sig_before = sg[0];
    repeat (3) tick();
    n_vec++;
    if ({sg[0], st[0]} !== {sig_before, 16'h1002}) begin
      n_err++; $display("FAIL abort_hold: got sig=%h st=%h want %h/1002", sg[0], st[0], sig_before);
    end
  endtask

  task automatic test_timing();
    int e;
    do_reset();
    sel = 2;
    do_run(20, -1, e);
    n_vec++;
    if (e != 4) begin n_err++; $display("FAIL timing_min_latency: got %0d edges want 4", e); end
    n_vec++;
    if ({sg[2], st[2]} !== {fold(5'h01, 1, 0), 16'hC001} || xs.size() != 1) begin
      n_err++; $display("FAIL timing_min_result: got sig=%h st=%h n=%0d want %h/C001/1", sg[2], st[2], xs.size(), fold(5'h01, 1, 0));
    end
  endtask

  task automatic test_random_runs();
    int e;
    bit ok, p;
    logic [15:0] exp_sig;
    sel = 3;
    repeat (4) begin
      for (int i = 0; i < 32; i++) tbl[i] = 4'($urandom);
      do_reset();
      do_run(100, -1, e);
      exp_sig = fold(5'h13, 20, 1);
      p = (exp_sig == 16'h1234);
      n_vec++;
      if (e != 26) begin n_err++; $display("FAIL rand_done_latency: got %0d edges want 26", e); end
      ok = (xs.size() == 20);
      for (int k = 0; k < 20 && ok; k++) if (xs[k] !== lfsr_at(5'h13, k)) ok = 0;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rand_core_x_seq: got %0d patterns want 20 from seed 13", xs.size()); end
      n_vec++;
      if (sg[3] !== exp_sig) begin n_err++; $display("FAIL rand_sig: got %h want %h", sg[3], exp_sig); end
      n_vec++;
      if ({ps[3], st[3]} !== {p, 1'b1, p, 2'b00, 12'd20}) begin
        n_err++; $display("FAIL rand_status: got pass=%b st=%h want %b/%h", ps[3], st[3], p, {1'b1, p, 2'b00, 12'd20});
      end
    end
  endtask

  task automatic test_random_abort();
    int j, c, nc;
    sel = 3;
    repeat (4) begin
      for (int i = 0; i < 32; i++) tbl[i] = 4'($urandom);
      do_reset();
      j = $urandom_range(0, 19);
      start = 1'b1; tick(); start = 1'b0;
      c = 0;
      while (en[3] !== 1'b1 && c < 10) begin tick(); c++; end
      n_vec++;
      if (en[3] !== 1'b1) begin n_err++; $display("FAIL rand_abort_run_entry: got en=%b want 1", en[3]); end
      repeat (j) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      nc = (j > 3) ? j - 3 : 0;
      n_vec++;
      if ({en[3], dn[3], st[3]} !== {2'b00, 4'b0001, 12'(j)}) begin
        n_err++; $display("FAIL rand_abort_status: got en=%b done=%b st=%h want 0/0/%h", en[3], dn[3], st[3], {4'b0001, 12'(j)});
      end
      n_vec++;
      if (sg[3] !== fold(5'h13, nc, 1)) begin n_err++; $display("FAIL rand_abort_sig: got %h want %h (j=%0d)", sg[3], fold(5'h13, nc, 1), j); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = 4'h0;
    tick(); tick();
    test_reset();
    test_nominal();
    test_start_in_done();
    test_start_during_run();
    test_start_abort_idle();
    test_abort();
    test_timing();
    test_random_runs();
    test_random_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
